rbm_load_sched: RTL

//  Upstream scheduler for the RBM DMA load stage. Latches the run configuration and walks the user records.

---
 rtl/rbm_pkg.sv | 32 +++
 rtl/rbm_rec_addr_gen.sv | 45 ++++
 rtl/rbm_load_sched.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rbm_pkg.sv
// Shared definitions for the RBM load scheduler: FSM states, address-generator
// operations, count width, legal record length and the record-length helper.
package rbm_pkg;

  localparam int CNT_W = 16;

  // Largest legal record length; the loader's trailing marker sits at address rd_length.
  localparam logic [CNT_W-1:0] MAX_LEN = 16'd511;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_REQ,
    ST_XFER,
    ST_HOLD,
    ST_NEXT,
    ST_DONE
  } sched_state_t;

  typedef enum logic [2:0] {
    ADDR_HOLD,
    ADDR_BASE,
    ADDR_SKIP,
    ADDR_STEP,
    ADDR_TEST
  } addr_op_t;

  function automatic logic [31:0] rec_len(input logic [CNT_W-1:0] movies);
    return {{(32 - CNT_W){1'b0}}, movies};
  endfunction

endpackage

// File: rtl/rbm_rec_addr_gen.sv
// Record address generator: rd_index accumulator plus the test-pass base,
// snapshotted as the accumulator steps past the last user of training loop 0.
module rbm_rec_addr_gen
  import rbm_pkg::*;
#(
  parameter logic [31:0] TRAIN_BASE = 32'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  addr_op_t         op,
  input  logic             snap_en,
  input  logic [CNT_W-1:0] num_users,
  input  logic [CNT_W-1:0] num_movies,
  output logic [31:0]      rd_index
);

  logic [31:0] test_base;
  logic [31:0] step_idx;
  logic [31:0] skip_idx;

  assign step_idx = rd_index + rec_len(num_movies);

  // Only used once at configuration time when training is skipped, so no
  // accumulator snapshot exists yet.
  assign skip_idx = TRAIN_BASE + rec_len(num_users) * rec_len(num_movies);

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register sees the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_index  <= '0;
      test_base <= '0;
    end else begin
      if (snap_en) test_base <= step_idx;
      case (op)
        ADDR_BASE: rd_index <= TRAIN_BASE;
        ADDR_SKIP: rd_index <= skip_idx;
        ADDR_STEP: rd_index <= step_idx;
        ADDR_TEST: rd_index <= test_base;
        default:   rd_index <= rd_index;
      endcase
    end
  end

endmodule

// File: rtl/rbm_load_sched.sv
// RBM DMA load-stage scheduler: latches the run configuration, then walks the
// training loops and the test pass, handshaking with arbiter, loader and compute.
module rbm_load_sched
  import rbm_pkg::*;
#(
  parameter logic [31:0] TRAIN_BASE = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        conf_done,
  input  logic [31:0] conf_num_users,
  input  logic [31:0] conf_num_testusers,
  input  logic [31:0] conf_num_movies,
  input  logic [31:0] conf_num_loops,
  input  logic        rd_grant,
  input  logic        ld_complete,
  input  logic        buf_taken,
  output logic        rd_request,
  output logic [31:0] rd_index,
  output logic [31:0] rd_length,
  output logic        ld_start,
  output logic        buf_valid,
  output logic        test_phase,
  output logic [15:0] user_idx,
  output logic [15:0] loop_idx,
  output logic        init_done,
  output logic        sched_done,
  output logic        cfg_err
);

  sched_state_t     state;
  logic [CNT_W-1:0] num_users;
  logic [CNT_W-1:0] num_testusers;
  logic [CNT_W-1:0] num_movies;
  logic [CNT_W-1:0] num_loops;

  logic             len_bad;
  logic             skip_train;
  logic [CNT_W-1:0] user_nxt;
  logic [CNT_W-1:0] loop_nxt;
  logic [CNT_W-1:0] pass_cnt;
  logic             pass_end;
  logic             last_loop;
  addr_op_t         addr_op;
  logic             snap_en;

  assign len_bad    = (num_movies == '0) || (num_movies > MAX_LEN);
  assign skip_train = (num_loops == '0) || (num_users == '0);
  assign user_nxt   = user_idx + CNT_W'(1);
  assign loop_nxt   = loop_idx + CNT_W'(1);
  assign pass_cnt   = test_phase ? num_testusers : num_users;
  assign pass_end   = (user_nxt == pass_cnt);
  assign last_loop  = !(loop_nxt < num_loops);
  assign rd_length  = rec_len(num_movies);

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    addr_op = ADDR_HOLD;
    snap_en = 1'b0;
    case (state)
      ST_CFG: begin
        if (!len_bad) addr_op = skip_train ? ADDR_SKIP : ADDR_BASE;
      end
      ST_NEXT: begin
        if (!pass_end) begin
          addr_op = ADDR_STEP;
        end else if (!test_phase) begin
          snap_en = (loop_idx == '0);
          if (!last_loop)           addr_op = ADDR_BASE;
          else if (loop_idx == '0)  addr_op = ADDR_STEP;
          else                      addr_op = ADDR_TEST;
        end
      end
      default: ;
    endcase
  end

  rbm_rec_addr_gen #(
    .TRAIN_BASE(TRAIN_BASE)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .op        (addr_op),
    .snap_en   (snap_en),
    .num_users (num_users),
    .num_movies(num_movies),
    .rd_index  (rd_index)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      num_users     <= '0;
      num_testusers <= '0;
      num_movies    <= '0;
      num_loops     <= '0;
      rd_request    <= 1'b0;
      ld_start      <= 1'b0;
      buf_valid     <= 1'b0;
      test_phase    <= 1'b0;
      user_idx      <= '0;
      loop_idx      <= '0;
      init_done     <= 1'b0;
      sched_done    <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      ld_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (conf_done) begin
            num_users     <= conf_num_users[CNT_W-1:0];
            num_testusers <= conf_num_testusers[CNT_W-1:0];
            num_movies    <= conf_num_movies[CNT_W-1:0];
            num_loops     <= conf_num_loops[CNT_W-1:0];
            state         <= ST_CFG;
          end
        end
        ST_CFG: begin
          init_done <= 1'b1;
          if (len_bad) begin
            cfg_err    <= 1'b1;
            sched_done <= 1'b1;
            state      <= ST_DONE;
          end else if (skip_train && num_testusers == '0) begin
            test_phase <= 1'b1;
            sched_done <= 1'b1;
            state      <= ST_DONE;
          end else begin
            test_phase <= skip_train;
            rd_request <= 1'b1;
            state      <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (rd_grant) begin
            rd_request <= 1'b0;
            ld_start   <= 1'b1;
            state      <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (ld_complete) begin
            buf_valid <= 1'b1;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (buf_taken) begin
            buf_valid <= 1'b0;
            state     <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (!pass_end) begin
            user_idx   <= user_nxt;
            rd_request <= 1'b1;
            state      <= ST_REQ;
          end else if (!test_phase && !last_loop) begin
            loop_idx   <= loop_nxt;
            user_idx   <= '0;
            rd_request <= 1'b1;
            state      <= ST_REQ;
          end else if (!test_phase && num_testusers != '0) begin
            test_phase <= 1'b1;
            user_idx   <= '0;
            rd_request <= 1'b1;
            state      <= ST_REQ;
          end else begin
            sched_done <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
